vec_loader: RTL
===============

VEC_LOADER -- requirements
Module: vec_loader

Interface
REQ-001 Parameter DATA_W, default 32: element and stream word width.
REQ-002 Parameter DEPTH, default 256: entries per vector bank; ADDR_W = clog2(DEPTH).
REQ-003 sys_clk  input  1  clock; all logic on the rising edge.
REQ-004 sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  host stream word valid.
REQ-006 in_ready  output  1  block accepts a word; transfer occurs when in_valid and in_ready are both high on a clock edge.
REQ-007 in_data  input  DATA_W  host stream word.
REQ-008 clear  input  1  synchronous abort/restart request.
REQ-009 load_done  output  1  both vectors fully loaded; level signal.
REQ-010 load_err  output  1  protocol error; level signal.
REQ-011 vec_len  output  32  accepted element count n.
REQ-012 rd_addr  input  ADDR_W  consumer-kernel read index.
REQ-013 rd_a  output  DATA_W  bank A word at rd_addr, registered.
REQ-014 rd_b  output  DATA_W  bank B word at rd_addr, registered.

Function
REQ-015 Stream format SHALL be: header word n, then n words for bank A (index 0..n-1), then n words for bank B (index 0..n-1).
REQ-016 FSM states SHALL be IDLE, LOAD_A, LOAD_B, DONE, ERR (plus CKSUM per REQ-030).
REQ-017 IDLE: on header transfer, latch vec_len=n and zero the index; n=0 -> DONE; 1..DEPTH -> LOAD_A; n>DEPTH -> ERR.
REQ-018 LOAD_A: each transfer writes bank A[index] and increments index; the transfer at index n-1 resets index to 0 and moves to LOAD_B.
REQ-019 LOAD_B: same as LOAD_A for bank B; the final transfer moves to DONE.
REQ-020 in_ready SHALL be high in IDLE/LOAD_A/LOAD_B and low in DONE/ERR; in_ready SHALL not depend combinationally on in_valid.
REQ-021 load_done is high exactly while in DONE; load_err is high exactly while in ERR; both SHALL assert the cycle after the causing transfer.
REQ-022 DONE and ERR SHALL be held until clear; no stream word is consumed in either state.
REQ-023 clear in any state -> IDLE next cycle, with vec_len=0, index=0, load_done=0, load_err=0; clear SHALL take priority over a simultaneous transfer, which is discarded (no bank write).
REQ-024 Read port latency SHALL be 1 cycle: rd_a/rd_b reflect rd_addr sampled on the previous edge; reads SHALL be allowed in every state.
REQ-025 Read and write of the same address in the same cycle SHALL return the old data; the new data is visible on the following read.
REQ-026 Index counter SHALL be ADDR_W+1 bits wide so that DEPTH is representable without wrap; the header compare SHALL be an unsigned 32-bit compare.

Reset
REQ-027 Reset SHALL force state IDLE, index 0, vec_len 0, load_done 0, load_err 0, rd_a 0, rd_b 0; in_ready SHALL be 1 after reset release.
REQ-028 Bank contents SHALL NOT be reset; reset during a load SHALL abandon it, and partially written contents are undefined.

Configuration
REQ-029 Macro VEC_LOADER_CKSUM_EN selects a trailing checksum word.
REQ-030 With VEC_LOADER_CKSUM_EN: LOAD_B final transfer -> CKSUM; one more word is accepted and compared with the 32-bit wrap-around sum of the header and all 2n data words; match -> DONE, mismatch -> ERR; for n=0 IDLE -> CKSUM.
REQ-031 Without VEC_LOADER_CKSUM_EN: no CKSUM state and no accumulator; behaviour per REQ-017..019.

Structure
REQ-032 Package vec_loader_pkg SHALL hold the state enum typedef, DATA_W/DEPTH defaults, and derived ADDR_W.
REQ-033 One sub-module vec_bank (1-write/1-read synchronous RAM, DEPTH x DATA_W, registered read) SHALL be instantiated twice, once for A and once for B.

Verification
REQ-034 Stream 3,1,2,3,4,5,6 with in_valid held high -> load_done=1 one cycle after word 7, vec_len=3; reading addr 0..2 gives rd_a=1,2,3 and rd_b=4,5,6.
REQ-035 Header 0 -> DONE the next cycle, vec_len=0, in_ready=0; with CKSUM_EN, trailing word 0 -> DONE and trailing word 1 -> ERR.
REQ-036 Header 257 with DEPTH=256 -> load_err=1, in_ready=0; assert clear -> IDLE next cycle with load_err=0; header 256 followed by 512 words -> load_done=1.
REQ-037 Random in_valid gaps on stream 2,10,20,30,40 -> same bank contents as the gap-free run; no word is lost or duplicated.
REQ-038 clear asserted together with the 2nd A word -> that word is not written, state is IDLE, and the next word is taken as a header.
REQ-039 Async reset pulse mid-LOAD_B -> all outputs 0 immediately, in_ready=1 after release; a new full load then completes correctly.

Source files
------------

// File: rtl/vec_loader_pkg.sv
// Shared types and default sizing for the vector loader slice.
// Optional checksum state is compiled in with VEC_LOADER_CKSUM_EN.
package vec_loader_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 256;
  localparam int DEF_ADDR_W = $clog2(DEF_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_A = 3'd1,
    ST_LOAD_B = 3'd2,
    ST_DONE   = 3'd3,
`ifdef VEC_LOADER_CKSUM_EN
    ST_ERR    = 3'd4,
    ST_CKSUM  = 3'd5
`else
    ST_ERR    = 3'd4
`endif
  } state_e;

endpackage

// File: rtl/vec_bank.sv
// Single-write / single-read synchronous RAM with a registered read port.
// Storage is never reset; only the read register clears.
module vec_bank
  import vec_loader_pkg::*;
#(
  parameter int  DATA_W = vec_loader_pkg::DEF_DATA_W,
  parameter int  DEPTH  = vec_loader_pkg::DEF_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge sys_clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Non-blocking update means a same-address write returns the old word.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) rdata_q <= '0;
    else            rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/vec_loader.sv
// Loads two equal-length vectors from a header-prefixed host stream into banks A/B.
// Define VEC_LOADER_CKSUM_EN to require a trailing 32-bit sum word after bank B.
module vec_loader
  import vec_loader_pkg::*;
#(
  parameter int  DATA_W = vec_loader_pkg::DEF_DATA_W,
  parameter int  DEPTH  = vec_loader_pkg::DEF_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              clear,
  output logic              load_done,
  output logic              load_err,
  output logic [31:0]       vec_len,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_a,
  output logic [DATA_W-1:0] rd_b
);

  localparam logic [ADDR_W:0] IDX_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_e          state_q, state_d;
  logic [ADDR_W:0] idx_q, idx_d;
  logic [31:0]     len_q, len_d;
  logic [31:0]     word32;
  logic            xfer;
  logic            last_elem;
  logic            we_a, we_b;
`ifdef VEC_LOADER_CKSUM_EN
  logic [31:0]     sum_q, sum_d;
`endif

  assign word32    = 32'(in_data);
  assign xfer      = in_valid && in_ready;
  assign last_elem = (32'(idx_q) == (len_q - 32'd1));

  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      ST_IDLE, ST_LOAD_A, ST_LOAD_B: in_ready = 1'b1;
`ifdef VEC_LOADER_CKSUM_EN
      ST_CKSUM:                      in_ready = 1'b1;
`endif
      default:                       in_ready = 1'b0;
    endcase
  end

  // Clear wins over any same-cycle transfer, so no bank write is issued then.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    we_a    = 1'b0;
    we_b    = 1'b0;
`ifdef VEC_LOADER_CKSUM_EN
    sum_d   = sum_q;
`endif
    if (clear) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      len_d   = '0;
`ifdef VEC_LOADER_CKSUM_EN
      sum_d   = '0;
`endif
    end else if (xfer) begin
      case (state_q)
        ST_IDLE: begin
          len_d = word32;
          idx_d = '0;
`ifdef VEC_LOADER_CKSUM_EN
          sum_d = word32;
          if (word32 == 32'd0)               state_d = ST_CKSUM;
`else
          if (word32 == 32'd0)               state_d = ST_DONE;
`endif
          else if (word32 > 32'(DEPTH))      state_d = ST_ERR;
          else                               state_d = ST_LOAD_A;
        end
        ST_LOAD_A: begin
          we_a = 1'b1;
`ifdef VEC_LOADER_CKSUM_EN
          sum_d = sum_q + word32;
`endif
          if (last_elem) begin
            idx_d   = '0;
            state_d = ST_LOAD_B;
          end else begin
            idx_d   = idx_q + IDX_ONE;
          end
        end
        ST_LOAD_B: begin
          we_b = 1'b1;
`ifdef VEC_LOADER_CKSUM_EN
          sum_d = sum_q + word32;
`endif
          if (last_elem) begin
            idx_d   = '0;
`ifdef VEC_LOADER_CKSUM_EN
            state_d = ST_CKSUM;
`else
            state_d = ST_DONE;
`endif
          end else begin
            idx_d   = idx_q + IDX_ONE;
          end
        end
`ifdef VEC_LOADER_CKSUM_EN
        ST_CKSUM: begin
          state_d = (word32 == sum_q) ? ST_DONE : ST_ERR;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
`ifdef VEC_LOADER_CKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
`ifdef VEC_LOADER_CKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  assign load_done = (state_q == ST_DONE);
  assign load_err  = (state_q == ST_ERR);
  assign vec_len   = len_q;

  vec_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_bank_a (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .we_i      (we_a),
    .waddr_i   (idx_q[ADDR_W-1:0]),
    .wdata_i   (in_data),
    .raddr_i   (rd_addr),
    .rdata_o   (rd_a)
  );

  vec_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_bank_b (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .we_i      (we_b),
    .waddr_i   (idx_q[ADDR_W-1:0]),
    .wdata_i   (in_data),
    .raddr_i   (rd_addr),
    .rdata_o   (rd_b)
  );

endmodule
